// File: rtl/map_manager.sv
// map_manager: owns the live ROWS x COLS tile map.
// It loads each level from tile ROM, clears enemy tiles on kill requests, and moves to the
// next level when the ladder tile is touched.
// Build option MAPMGR_WRAP_EN: when defined, advancing past the last map wraps to map 0.
// When it is not defined, advancing past the last map enters DONE and the game_done output exists.
module map_manager #(
    parameter int NUM_MAPS    = 4,
    parameter int ROWS        = 20,
    parameter int COLS        = 20,
    parameter int LADDER_TILE = 7,
    parameter int FLOOR_TILE  = 0
) (
    input  logic                         Clk,
    input  logic                         reset_n,
    input  logic [4:0]                   collisionTile,
    input  logic                         enemyOverlap,
    input  logic [4:0]                   currRow,
    input  logic [4:0]                   currCol,
    output logic [10:0]                  rom_addr,
    input  logic [4:0]                   rom_data,
    output logic [0:ROWS*COLS-1][4:0]    outMapData,
    output logic [1:0]                   map_index,
    output logic                         map_valid,
    output logic                         load_busy,
    output logic [8:0]                   enemies_left,
`ifndef MAPMGR_WRAP_EN
    output logic                         game_done,
`endif
    output logic                         level_clear
);

    localparam int TILES = ROWS * COLS;
    localparam int CW    = $clog2(TILES + 1);
    localparam int TW    = $clog2(TILES);

    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_DONE} state_t;

    state_t                      state_q, state_d;
    logic [CW-1:0]               ctr_q;
    logic [1:0]                  map_idx_q;
    logic [10:0]                 rom_addr_q;
    logic [0:TILES-1][4:0]       map_q;
    logic                        map_valid_q;
    logic [8:0]                  enemies_q;
    logic                        prev_adv_q;
    logic                        prev_kill_q;

    logic                        is_ladder;
    logic                        adv;
    logic                        kill_req;
    logic                        in_range;
    logic                        kill_hit;
    logic                        last_map;
    logic                        adv_to_done;
    logic [1:0]                  next_idx;
    logic [TW-1:0]               kill_tidx;
    int                          kidx;

    function automatic logic is_enemy(input logic [4:0] code);
        return (code == 5'd3) || (code == 5'd4) || (code >= 5'd10 && code <= 5'd13);
    endfunction

    function automatic logic [10:0] map_base(input logic [1:0] idx);
        return 11'(idx) * 11'(TILES);
    endfunction

    // Request edge detection, kill address decode and next-level selection.
    always_comb begin
        is_ladder = (collisionTile == 5'(LADDER_TILE));
        adv       = is_ladder & ~prev_adv_q;
        kill_req  = enemyOverlap & ~prev_kill_q;
        in_range  = (int'(currRow) < ROWS) && (int'(currCol) < COLS);
        kidx      = int'(currRow) * COLS + int'(currCol);
        kill_tidx = in_range ? TW'(kidx) : '0;
        kill_hit  = kill_req & in_range & is_enemy(map_q[kill_tidx]);
        last_map  = (map_idx_q == 2'(NUM_MAPS - 1));
        next_idx  = last_map ? 2'd0 : map_idx_q + 2'd1;
`ifdef MAPMGR_WRAP_EN
        adv_to_done = 1'b0;
`else
        adv_to_done = last_map;
`endif
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (!reset_n) state_q <= S_LOAD;
        else          state_q <= state_d;
    end

    // FSM next-state: LOAD runs TILES+1 cycles, IDLE leaves on a ladder edge, DONE is terminal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (ctr_q == CW'(TILES)) state_d = S_IDLE;
            S_IDLE:  if (adv) state_d = adv_to_done ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_LOAD;
        endcase
    end

    // FSM-decoded status outputs.
    always_comb begin
        load_busy   = (state_q == S_LOAD);
        level_clear = map_valid_q && (enemies_q == 9'd0);
`ifndef MAPMGR_WRAP_EN
        game_done   = (state_q == S_DONE);
`endif
    end

    // Map datapath: ROM streaming during LOAD, kills and level advance in IDLE.
    always_ff @(posedge Clk) begin
        if (!reset_n) begin
            ctr_q       <= '0;
            map_idx_q   <= '0;
            rom_addr_q  <= '0;
            map_q       <= '0;
            map_valid_q <= 1'b0;
            enemies_q   <= '0;
            prev_adv_q  <= 1'b0;
            prev_kill_q <= 1'b0;
        end else begin
            prev_adv_q  <= is_ladder;
            prev_kill_q <= enemyOverlap;
            case (state_q)
                S_LOAD: begin
                    // ROM data arriving now belongs to the address issued one cycle earlier.
                    if (ctr_q != '0) begin
                        map_q[TW'(ctr_q - CW'(1))] <= rom_data;
                        if (is_enemy(rom_data)) enemies_q <= enemies_q + 9'd1;
                    end
                    if (ctr_q < CW'(TILES - 1)) rom_addr_q <= rom_addr_q + 11'd1;
                    if (ctr_q == CW'(TILES)) begin
                        ctr_q       <= '0;
                        map_valid_q <= 1'b1;
                    end else begin
                        ctr_q <= ctr_q + CW'(1);
                    end
                end
                S_IDLE: begin
                    // Advance has priority; a simultaneous kill is dropped.
                    if (adv) begin
                        if (!adv_to_done) begin
                            map_idx_q   <= next_idx;
                            rom_addr_q  <= map_base(next_idx);
                            map_valid_q <= 1'b0;
                            enemies_q   <= '0;
                            ctr_q       <= '0;
                        end
                    end else if (kill_hit) begin
                        map_q[kill_tidx] <= 5'(FLOOR_TILE);
                        enemies_q        <= enemies_q - 9'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rom_addr     = rom_addr_q;
    assign outMapData   = map_q;
    assign map_index    = map_idx_q;
    assign map_valid    = map_valid_q;
    assign enemies_left = enemies_q;

endmodule
